rainbow_led: RTL and testbench

//  Drives a 3-channel RGB LED so it continuously sweeps the full hue wheel
//  (red->yellow->green->cyan->blue->magenta->red).

---
 rtl/rainbow_led.sv | 125 ++++++++++++
 tb/tb_rainbow_led.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rainbow_led.sv
// -----------------------------------------------------------------------------
// rainbow_led
//   Sweeps an RGB LED around the full hue wheel
//   (red -> yellow -> green -> cyan -> blue -> magenta -> red).
//   An 11-bit hue (0..1535) advances once every CYCLES_PER_STEP clocks. Each
//   hue maps to an 8-bit duty per channel, and each channel is PWM-dimmed by
//   a free-running 8-bit counter.
//
// Parameters
//   CYCLES_PER_STEP : clocks per hue increment (>= 1)
//   ACTIVE_LOW      : 1 -> pin low lights the LED, 0 -> pin high lights it
//
// Ports
//   clk   : system clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   led   : [0]=red [1]=green [2]=blue, registered, polarity per ACTIVE_LOW
// -----------------------------------------------------------------------------
module rainbow_led #(
    parameter int CYCLES_PER_STEP = 16384,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] led
);

    localparam int                STEP_W    = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CYCLES_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [10:0]       HUE_LAST  = 11'd1535;
    localparam logic [2:0]        LED_OFF   = {3{ACTIVE_LOW}};

    // Hue-to-colour map, packed as {blue, green, red}. Sector = hue[10:8],
    // fraction = hue[7:0]. Sectors 6 and 7 are unreachable; they fall back to
    // the hue-0 colour.
    function automatic logic [23:0] hue_to_rgb(input logic [10:0] hue);
        logic [7:0] f;
        f = hue[7:0];
        case (hue[10:8])
            3'd0:    hue_to_rgb = {8'd0,        f,           8'd255};
            3'd1:    hue_to_rgb = {8'd0,        8'd255,      8'd255 - f};
            3'd2:    hue_to_rgb = {f,           8'd255,      8'd0};
            3'd3:    hue_to_rgb = {8'd255,      8'd255 - f,  8'd0};
            3'd4:    hue_to_rgb = {8'd255,      8'd0,        f};
            3'd5:    hue_to_rgb = {8'd255 - f,  8'd0,        8'd255};
            default: hue_to_rgb = {8'd0,        8'd0,        8'd255};
        endcase
    endfunction

    logic [STEP_W-1:0] step_cnt_r;
    logic [10:0]       hue_r;
    logic [7:0]        pwm_cnt_r;
    logic [7:0]        duty_r_r;
    logic [7:0]        duty_g_r;
    logic [7:0]        duty_b_r;
    logic [2:0]        led_r;

    logic              step_wrap_s;
    logic              pwm_wrap_s;
    logic [23:0]       rgb_s;
    logic [2:0]        on_s;

    // Wrap detection, colour lookup and PWM compare for the current clock.
    always_comb begin
        step_wrap_s = (step_cnt_r == STEP_LAST);
        pwm_wrap_s  = (pwm_cnt_r == 8'd255);
        rgb_s       = hue_to_rgb(hue_r);
        on_s        = {(pwm_cnt_r < duty_b_r),
                       (pwm_cnt_r < duty_g_r),
                       (pwm_cnt_r < duty_r_r)};
    end

    // Step counter and hue: hue advances once per completed step, wrapping 1535 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt_r <= '0;
            hue_r      <= 11'd0;
        end else if (step_wrap_s) begin
            step_cnt_r <= '0;
            hue_r      <= (hue_r == HUE_LAST) ? 11'd0 : hue_r + 11'd1;
        end else begin
            step_cnt_r <= step_cnt_r + STEP_ONE;
            hue_r      <= hue_r;
        end
    end

    // Free-running PWM counter; wraps naturally from 255 to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_r <= 8'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end
    end

    // Duty registers. They reload only on the last slot of a PWM period, so a
    // hue change never alters a period that is already running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_r_r <= 8'd255;
            duty_g_r <= 8'd0;
            duty_b_r <= 8'd0;
        end else if (pwm_wrap_s) begin
            duty_r_r <= rgb_s[7:0];
            duty_g_r <= rgb_s[15:8];
            duty_b_r <= rgb_s[23:16];
        end else begin
            duty_r_r <= duty_r_r;
            duty_g_r <= duty_g_r;
            duty_b_r <= duty_b_r;
        end
    end

    // Registered pin drive with polarity applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_r <= LED_OFF;
        end else begin
            led_r <= on_s ^ LED_OFF;
        end
    end

    assign led = led_r;

endmodule

// File: tb/tb_rainbow_led.sv
// -----------------------------------------------------------------------------
// tb_rainbow_led
//   Four rainbow_led instances with different parameters share one clock and
//   one reset. A closed-form model predicts every LED pin on every cycle from
//   the number of clocks since the last reset. Per-period on-counts are also
//   checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rainbow_led;

    logic       clk;
    logic       rst_n;
    logic [2:0] led_a;   // CYCLES_PER_STEP=4, ACTIVE_LOW=1
    logic [2:0] led_b;   // CYCLES_PER_STEP=3, ACTIVE_LOW=0
    logic [2:0] led_c;   // default parameters
    logic [2:0] led_d;   // CYCLES_PER_STEP=1, ACTIVE_LOW=1

    rainbow_led #(.CYCLES_PER_STEP(4), .ACTIVE_LOW(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .led(led_a));
    rainbow_led #(.CYCLES_PER_STEP(3), .ACTIVE_LOW(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .led(led_b));
    rainbow_led u_c (.clk(clk), .rst_n(rst_n), .led(led_c));
    rainbow_led #(.CYCLES_PER_STEP(1), .ACTIVE_LOW(1'b1)) u_d (.clk(clk), .rst_n(rst_n), .led(led_d));

    int     checks = 0;
    int     errors = 0;
    longint n      = 0;     // rising edges since reset release
    bit     in_rst = 1'b0;  // last edge sampled rst_n low
    bit     started = 1'b0;
    bit     clean  = 1'b1;  // no reset since the first release
    int     cnt_a[3];
    int     cnt_b[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Red intensity as a function of hue; green and blue are the same curve
    // shifted around the wheel by 512 and 1024 steps.
    function automatic int red_of(input longint x);
        int f;
        f = int'(x % 256);
        if (x < 256 || x >= 1280) return 255;
        else if (x < 512)         return 255 - f;
        else if (x < 1024)        return 0;
        else                      return f;
    endfunction

    // Expected pins after the edge at index p (p = 0 is the first edge after
    // reset release). The duty in force was captured at the last period end
    // strictly before p, whose hue is (index / C) mod 1536.
    function automatic logic [2:0] model_led(input longint p, input int c, input bit al);
        longint blk;
        longint hue;
        int     duty[3];
        int     slot;
        logic [2:0] res;
        blk  = p / 256;
        hue  = (blk == 0) ? 0 : (((blk * 256) - 1) / c) % 1536;
        slot = int'(p % 256);
        duty[0] = red_of(hue);
        duty[1] = red_of((hue + 1024) % 1536);
        duty[2] = red_of((hue + 512) % 1536);
        for (int i = 0; i < 3; i++) res[i] = (slot < duty[i]) ^ al;
        return res;
    endfunction

    task automatic check_led(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %b expected %b", name, n, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: on-count %0d expected %0d", name, act, exp);
        end
    endtask

    // Reset/edge tracker for the model.
    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n) begin
            in_rst <= 1'b1;
            n      <= 0;
        end else begin
            in_rst <= 1'b0;
            n      <= n + 1;
        end
    end

    // Compare process: every cycle, every instance, on the falling edge.
    always @(negedge clk) begin
        longint     p;
        logic [2:0] on_a;
        logic [2:0] on_b;
        if (started) begin
            if (in_rst) begin
                check_led("reset_a", led_a, 3'b111);
                check_led("reset_b", led_b, 3'b000);
                check_led("reset_c", led_c, 3'b111);
                check_led("reset_d", led_d, 3'b111);
            end else begin
                p = n - 1;
                check_led("led_a", led_a, model_led(p, 4, 1'b1));
                check_led("led_b", led_b, model_led(p, 3, 1'b0));
                check_led("led_c", led_c, model_led(p, 16384, 1'b1));
                check_led("led_d", led_d, model_led(p, 1, 1'b1));
                if (clean) begin
                    on_a = ~led_a;
                    on_b = led_b;
                    for (int i = 0; i < 3; i++) begin
                        if (p % 256 == 0) begin
                            cnt_a[i] <= int'(on_a[i]);
                            cnt_b[i] <= int'(on_b[i]);
                        end else begin
                            cnt_a[i] <= cnt_a[i] + int'(on_a[i]);
                            cnt_b[i] <= cnt_b[i] + int'(on_b[i]);
                        end
                    end
                    // First period, hue 0: red 255/256, green and blue dark.
                    if (p == 255) begin
                        check_cnt("p0_a_red",   cnt_a[0] + int'(on_a[0]), 255);
                        check_cnt("p0_a_green", cnt_a[1] + int'(on_a[1]), 0);
                        check_cnt("p0_a_blue",  cnt_a[2] + int'(on_a[2]), 0);
                        check_cnt("p0_b_red",   cnt_b[0] + int'(on_b[0]), 255);
                        check_cnt("p0_b_green", cnt_b[1] + int'(on_b[1]), 0);
                    end
                    // Period 6 of u_a: duty captured at hue 383 (s1, f=127).
                    if (p == 1791) begin
                        check_cnt("p6_a_red",   cnt_a[0] + int'(on_a[0]), 128);
                        check_cnt("p6_a_green", cnt_a[1] + int'(on_a[1]), 255);
                        check_cnt("p6_a_blue",  cnt_a[2] + int'(on_a[2]), 0);
                    end
                    // Period 20 of u_a: duty captured at hue 1279 (s4, f=255).
                    if (p == 5375) begin
                        check_cnt("p20_a_red",   cnt_a[0] + int'(on_a[0]), 255);
                        check_cnt("p20_a_green", cnt_a[1] + int'(on_a[1]), 0);
                        check_cnt("p20_a_blue",  cnt_a[2] + int'(on_a[2]), 255);
                    end
                end
            end
        end
    end

    // Stimulus: reset hold, a long clean run through a full wheel, then
    // randomly spaced reset pulses.
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8000) @(negedge clk);
        clean = 1'b0;
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(1500, 100)) @(negedge clk);
            rst_n = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (300) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
